lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 27 ++
 rtl/lsu.sv | 156 +++++++++++++++
 tb/tb_lsu.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - memory bus interface between the LSU (master) and the data memory (slave)
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef REG_LENGTH_32I
`define REG_LENGTH_32I 32
`endif

interface lsu_if;
  logic                 bus_req_;
  logic                 bus_we;
  logic [`ADDR_LEN-1:0] bus_addr;
  logic [31:0]          bus_wdata;
  logic [3:0]           bus_be;
  logic                 bus_ack;
  logic [31:0]          bus_rdata;

  modport master (
    output bus_req_, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req_, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: IDLE/BUS/DONE sequencer, store lane steering, load alignment; LSU_MISALIGN_EN enables misaligned-access trapping
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef REG_LENGTH_32I
`define REG_LENGTH_32I 32
`endif

module lsu (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       mem_req_,
  input  logic                       mem_rw,
  input  logic [2:0]                 funct3,
  input  logic [`ADDR_LEN-1:0]       addr_i,
  input  logic [`REG_LENGTH_32I-1:0] wdata_i,
  input  logic [4:0]                 wb_addr_i,
  output logic                       stall_o,
  lsu_if.master                      bus,
  output logic                       wb_en_,
  output logic [4:0]                 wb_addr_o,
  output logic [`REG_LENGTH_32I-1:0] wb_data_o,
  output logic                       misalign_o
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        misaligned;
  logic        rw_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        flushed_q;
  logic        misalign_q;
  logic [3:0]  be_nxt;
  logic [31:0] wd_nxt;
  logic [1:0]  lane_sh;
  logic [31:0] lane;
  logic [31:0] ld_data;

  // A request is taken only from IDLE and only when the pipeline is not being flushed
  assign accept = rst_n && (state == IDLE) && !mem_req_ && !flush;

`ifdef LSU_MISALIGN_EN
  // funct3[1:0]: 00 byte, 01 half, 1x word
  assign misaligned = ((funct3[1:0] == 2'b01) && addr_i[0]) ||
                      (funct3[1] && (addr_i[1:0] != 2'b00));
  assign misalign_o = (state == DONE) && misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign bus.bus_req_ = (state != BUS);
  assign wb_en_       = !((state == DONE) && !rw_q && !flushed_q && !misalign_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and stall decode
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          state_nxt = misaligned ? DONE : BUS;
        end
      end
      BUS: begin
        stall_o = 1'b1;
        if (bus.bus_ack) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Store lane steering; loads always fetch the full word
  always_comb begin
    be_nxt = 4'b1111;
    wd_nxt = wdata_i;
    if (mem_rw) begin
      case (funct3[1:0])
        2'b00: begin
          be_nxt = 4'b0001 << addr_i[1:0];
          wd_nxt = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_nxt = 4'b0011 << {addr_i[1], 1'b0};
          wd_nxt = {2{wdata_i[15:0]}};
        end
        default: begin
          be_nxt = 4'b1111;
          wd_nxt = wdata_i;
        end
      endcase
    end
  end

  // Load lane select and sign/zero extension from the captured access
  always_comb begin
    case (f3_q[1:0])
      2'b00:   lane_sh = off_q;
      2'b01:   lane_sh = {off_q[1], 1'b0};
      default: lane_sh = 2'b00;
    endcase
    lane = bus.bus_rdata >> {lane_sh, 3'b000};
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_data = f3_q[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  // Capture the request, hold bus fields through BUS, note flushes, latch load data on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      flushed_q     <= 1'b0;
      misalign_q    <= 1'b0;
      wb_addr_o     <= 5'd0;
      wb_data_o     <= '0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= 32'h0;
      bus.bus_be    <= 4'b0000;
    end else begin
      if (accept) begin
        rw_q          <= mem_rw;
        f3_q          <= funct3;
        off_q         <= addr_i[1:0];
        flushed_q     <= 1'b0;
        misalign_q    <= misaligned;
        wb_addr_o     <= wb_addr_i;
        bus.bus_we    <= mem_rw;
        bus.bus_addr  <= {addr_i[`ADDR_LEN-1:2], 2'b00};
        bus.bus_wdata <= wd_nxt;
        bus.bus_be    <= be_nxt;
      end
      if (state == BUS) begin
        flushed_q <= flushed_q | flush;
        if (bus.bus_ack) wb_data_o <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - table-driven scoreboard bench for the lsu
module tb_lsu;

  typedef struct {
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req_ = 1'b1;
  logic        mem_rw = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [4:0]  wb_addr_i = 5'd0;
  logic        stall_o;
  logic        wb_en_;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vt[$];

  lsu_if bif();

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .mem_req_   (mem_req_),
    .mem_rw     (mem_rw),
    .funct3     (funct3),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wb_addr_i  (wb_addr_i),
    .stall_o    (stall_o),
    .bus        (bif),
    .wb_en_     (wb_en_),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " bus_req_"},   bif.bus_req_,  1);
    chk({tag, " bus_we"},     bif.bus_we,    0);
    chk({tag, " bus_addr"},   bif.bus_addr,  0);
    chk({tag, " bus_wdata"},  bif.bus_wdata, 0);
    chk({tag, " bus_be"},     bif.bus_be,    0);
    chk({tag, " wb_en_"},     wb_en_,        1);
    chk({tag, " wb_addr_o"},  wb_addr_o,     0);
    chk({tag, " wb_data_o"},  wb_data_o,     0);
    chk({tag, " misalign_o"}, misalign_o,    0);
    chk({tag, " stall_o"},    stall_o,       0);
  endtask

  // Scoreboard: every register-file write must match the oldest expected load result
  always @(negedge clk) begin
    if (rst_n && wb_en_ === 1'b0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got write rd=%0d data=%h, required no write", wb_addr_o, wb_data_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_addr", {27'h0, wb_addr_o}, {27'h0, mon_e.rd});
        chk("wb_data", wb_data_o, mon_e.data);
      end
    end
  end

  task automatic run_vec(input vec_t v, input logic [4:0] rd, input bit fl);
    int  stalls;
    sb_t e;
    @(posedge clk); #1;
    mem_req_ = 1'b0; mem_rw = v.rw; funct3 = v.f3;
    addr_i = v.addr; wdata_i = v.wdata; wb_addr_i = rd;
    if (!v.rw && !fl) begin
      e.rd = rd; e.data = v.data;
      sb_q.push_back(e);
    end
    @(negedge clk);
    stalls = stall_o ? 1 : 0;
    @(posedge clk); #1;
    mem_req_ = 1'b1; addr_i = 32'h0; wdata_i = 32'h0;
    for (int c = 1; c <= v.delay; c++) begin
      flush = fl && (c == 1);
      if (c == v.delay) begin
        bif.bus_ack = 1'b1; bif.bus_rdata = v.rdata;
      end
      @(negedge clk);
      if (stall_o) stalls++;
      chk("bus_req_", bif.bus_req_, 0);
      chk("bus_we",   bif.bus_we,   v.rw);
      chk("bus_addr", bif.bus_addr, v.baddr);
      chk("bus_be",   bif.bus_be,   v.be);
      if (v.rw) chk("bus_wdata", bif.bus_wdata, v.bwdata);
      @(posedge clk); #1;
      bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0; flush = 1'b0;
    end
    @(negedge clk);
    chk("stall_done", stall_o, 0);
    chk("wb_en_done", wb_en_, (!v.rw && !fl) ? 0 : 1);
    chk("stall_cycles", stalls, 1 + v.delay);
    @(posedge clk); #1;
    chk("sb_drained", sb_q.size(), 0);
    chk("idle_bus_req_", bif.bus_req_, 1);
  endtask

  initial begin
    bif.bus_ack = 1'b0;
    bif.bus_rdata = 32'h0;

    //           rw    f3      addr       wdata         rdata        dly be     baddr      bwdata        data
    vt.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF});
    vt.push_back('{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1, 4'hF, 32'h100, 32'h0,        32'hFFFFFF80});
    vt.push_back('{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1, 4'hF, 32'h100, 32'h0,        32'h00000080});
    vt.push_back('{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        2, 4'hC, 32'h200, 32'hABCDABCD, 32'h0});
    vt.push_back('{1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1, 4'h2, 32'h300, 32'hA5A5A5A5, 32'h0});
    vt.push_back('{1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0,        2, 4'hF, 32'h404, 32'hCAFEF00D, 32'h0});
    vt.push_back('{1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1, 4'hF, 32'h100, 32'h0,        32'hFFFF8001});
    vt.push_back('{1'b0, 3'b101, 32'h102, 32'h0,        32'h80011234, 2, 4'hF, 32'h100, 32'h0,        32'h00008001});
    vt.push_back('{1'b0, 3'b001, 32'h100, 32'h0,        32'h00007FFF, 1, 4'hF, 32'h100, 32'h0,        32'h00007FFF});
    vt.push_back('{1'b0, 3'b011, 32'h108, 32'h0,        32'h55AA55AA, 2, 4'hF, 32'h108, 32'h0,        32'h55AA55AA});
    vt.push_back('{1'b1, 3'b000, 32'h503, 32'h00000017, 32'h0,        1, 4'h8, 32'h500, 32'h17171717, 32'h0});
`ifndef LSU_MISALIGN_EN
    vt.push_back('{1'b0, 3'b010, 32'h101, 32'h0,        32'h11223344, 1, 4'hF, 32'h100, 32'h0,        32'h11223344});
    vt.push_back('{1'b0, 3'b001, 32'h103, 32'h0,        32'hBEEF0000, 1, 4'hF, 32'h100, 32'h0,        32'hFFFFBEEF});
`endif

    #2;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], 5'(i + 1), 1'b0);

    // Flush during BUS: bus cycle completes, writeback suppressed
    run_vec(vt[0], 5'd20, 1'b1);

    // Request while flushing in IDLE is dropped
    @(posedge clk); #1;
    mem_req_ = 1'b0; flush = 1'b1; mem_rw = 1'b0; funct3 = 3'b010; addr_i = 32'h700;
    @(negedge clk);
    chk("flush_idle stall_o", stall_o, 0);
    @(posedge clk); #1;
    mem_req_ = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle bus_req_", bif.bus_req_, 1);
    chk("flush_idle stall_o2", stall_o, 0);

    // Reset in BUS abandons the access; a late ack is ignored
    @(posedge clk); #1;
    mem_req_ = 1'b0; mem_rw = 1'b0; funct3 = 3'b010; addr_i = 32'h600; wb_addr_i = 5'd9;
    @(posedge clk); #1;
    mem_req_ = 1'b1;
    @(negedge clk);
    chk("rst_bus bus_req_", bif.bus_req_, 0);
    #1 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("late_ack wb_en_", wb_en_, 1);
    chk("late_ack bus_req_", bif.bus_req_, 1);
    @(posedge clk); #1;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    @(negedge clk);
    chk("late_ack wb_en_2", wb_en_, 1);
    chk("late_ack stall_o", stall_o, 0);

`ifdef LSU_MISALIGN_EN
    // Misaligned word load traps without a bus cycle or writeback
    @(posedge clk); #1;
    mem_req_ = 1'b0; mem_rw = 1'b0; funct3 = 3'b010; addr_i = 32'h101; wb_addr_i = 5'd3;
    @(negedge clk);
    chk("mis stall_o", stall_o, 1);
    @(posedge clk); #1;
    mem_req_ = 1'b1;
    @(negedge clk);
    chk("mis misalign_o", misalign_o, 1);
    chk("mis bus_req_", bif.bus_req_, 1);
    chk("mis wb_en_", wb_en_, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis pulse_end", misalign_o, 0);
    chk("mis bus_req_2", bif.bus_req_, 1);
`else
    chk("misalign_tied", misalign_o, 0);
`endif

    @(posedge clk); #1;
    chk("sb_final", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
